// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake; divide-by-zero short-circuits straight to DONE.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] d_r, q_r, r_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_sh, r_nxt, q_nxt;
  logic [WIDTH:0]   t;
  logic             last;

  // One shift-subtract step: the borrow bit of t decides restore vs. keep.
  assign r_sh  = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
  assign t     = {1'b0, r_sh} - {1'b0, d_r};
  assign r_nxt = t[WIDTH] ? r_sh : t[WIDTH-1:0];
  assign q_nxt = {q_r[WIDTH-2:0], ~t[WIDTH]};
  assign last  = (cnt == CW'(WIDTH - 1));

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = (divisor == '0) ? DONE : CALC;
      CALC:    if (last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r         <= '0;
      q_r         <= '0;
      r_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          d_r <= divisor;
          q_r <= dividend;
          r_r <= '0;
          cnt <= '0;
          // Zero divisor: results load now, no iterations are run.
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          r_r <= r_nxt;
          q_r <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (WIDTH=4): expected results queued at
// start acceptance, checked with latency and busy count when done pulses.
module tb_restoring_divider;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  logic         clk, rst_n, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  exp_t last_e;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Wait for IDLE, raise start with operands, queue the reference result.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", (n < 50) ? 1 : 0, 1);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.dz  = (b == 0);
    e.q   = (b == 0) ? {W{1'b1}} : W'(a / b);
    e.r   = (b == 0) ? a : W'(a % b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dz);
          chk("latency", cyc - e.acc, e.dz ? 0 : W);
          chk("busy_cycles", busy_cnt, e.dz ? 0 : W);
          last_e = e;
        end
        busy_cnt = 0;
      end else begin
        chk("hold", {div_by_zero, quotient, remainder}, {last_e.dz, last_e.q, last_e.r});
      end
    end
  end

  initial begin
    int n;
    last_e = '{q: '0, r: '0, dz: 1'b0, acc: 0};
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, done, div_by_zero, quotient, remainder}, 0);
    rst_n = 1'b1;

    // basic divide, then back-to-back with start held high
    do_div(4'd13, 4'd3, 0);
    do_div(4'd15, 4'd1, 1);
    do_div(4'd5, 4'd7, 0);

    // zero divisor then recovery
    do_div(4'd9, 4'd0, 0);
    do_div(4'd8, 4'd2, 0);

    // start/operand churn during CALC must be ignored
    do_div(4'd14, 4'd4, 0);
    for (int i = 0; i < 3; i++) begin
      start    = ~start;
      dividend = W'($urandom_range(0, 15));
      divisor  = W'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0;

    // asynchronous reset mid-CALC abandons the operation
    do_div(4'd11, 4'd2, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {busy, done, div_by_zero, quotient, remainder}, 0);
    sb.delete();
    last_e   = '{q: '0, r: '0, dz: 1'b0, acc: 0};
    busy_cnt = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_div(4'd11, 4'd2, 0);

    // exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_div(W'(a), W'(b), 0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
